// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops (ADD, SUB, AND, NOT, OR, XOR, SHL) finish on the accepting
// edge. MUL runs an unsigned shift-add loop, one multiplier bit per edge.
// Results and flags are registered and held until the consumer accepts them.
// The result stage passes through, so a new bundle can be accepted on the
// same edge that the consumer takes the previous result.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             C,
    output logic             busy
);

    // Bits of Bin that select the shift amount; this width also covers the multiply bit counter.
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    state_t state, state_next;

    logic       accept;
    logic       start_mul;
    logic       mul_last;
    op_t        op;

    // Single-cycle ALU results
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   shl_wide;

    // Shift-add multiplier state
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [SW-1:0]      cnt;

    assign op        = op_t'(ALUop);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (op == OP_MUL);
    assign mul_last  = (state == MUL) && (cnt == SW'(WIDTH - 1));
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = start_mul ? MUL : DONE;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (accept) begin
                    state_next = start_mul ? MUL : DONE;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle operation results and carry/overflow flags
    always_comb begin
        sum_wide = {1'b0, Ain} + {1'b0, Bin};
        diff     = Ain - Bin;
        // Widening by one bit keeps the last bit shifted out, and gives 0 for a zero shift.
        shl_wide = {1'b0, Ain} << Bin[SW-1:0];
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_wide[WIDTH-1:0];
                alu_c   = sum_wide[WIDTH];
                alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) &&
                          (sum_wide[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = (Ain >= Bin);
                alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) &&
                          (diff[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND: alu_res = Ain & Bin;
            OP_NOT: alu_res = ~Bin;
            OP_OR:  alu_res = Ain | Bin;
            OP_XOR: alu_res = Ain ^ Bin;
            OP_SHL: begin
                alu_res = shl_wide[WIDTH-1:0];
                alu_c   = shl_wide[WIDTH];
            end
            default: begin
                alu_res = '0;
            end
        endcase
    end

    // Multiplier iteration and the registered result/flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            out    <= '0;
            Z      <= 1'b0;
            V      <= 1'b0;
            N      <= 1'b0;
            C      <= 1'b0;
        end else if (accept) begin
            if (start_mul) begin
                mcand  <= {{WIDTH{1'b0}}, Ain};
                mplier <= Bin;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                out <= alu_res;
                Z   <= (alu_res == '0);
                V   <= alu_v;
                N   <= alu_res[WIDTH-1];
                C   <= alu_c;
            end
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SW'(1);
            if (mul_last) begin
                out <= acc_next[WIDTH-1:0];
                Z   <= (acc_next[WIDTH-1:0] == '0);
                V   <= |acc_next[2*WIDTH-1:WIDTH];
                N   <= acc_next[WIDTH-1];
                C   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16). A driver pushes the modelled
// result of each accepted bundle to a scoreboard queue; a monitor pops and
// compares whenever a result transfers. Directed checks cover reset, MUL
// timing, backpressure and reset in the middle of a multiply.
module tb_seq_alu;

    localparam int W = 16;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] NOT = 3'b011;
    localparam logic [2:0] OR  = 3'b100;
    localparam logic [2:0] XOR = 3'b101;
    localparam logic [2:0] SHL = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic [2:0]   ALUop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         Z;
    logic         V;
    logic         N;
    logic         C;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {out, Z, V, N, C}
    logic [W+3:0] sb_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .Z         (Z),
        .V         (V),
        .N         (N),
        .C         (C),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [W+3:0] obs();
        return {out, Z, V, N, C};
    endfunction

    // Reference behaviour for one bundle
    function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic           c;
        logic           v;
        int             sh;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            SUB: begin
                r = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            AND: r = a & b;
            NOT: r = ~b;
            OR:  r = a | b;
            XOR: r = a ^ b;
            SHL: begin
                sh = int'(b[3:0]);
                r  = a << sh;
                c  = (sh == 0) ? 1'b0 : a[W-sh];
            end
            default: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0];
                v = |p[2*W-1:W];
            end
        endcase
        return {r, (r == '0), v, r[W-1], c};
    endfunction

    // Scoreboard monitor: compare whenever a result transfers on the next edge
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check("sb_nonempty", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                check("sb_result", obs(), sb_q.pop_front());
            end
        end
    end

    // Present one bundle, wait for its acceptance, then for its result.
    // Called and returns at posedge+1.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc_ok;
        int   waits;
        int   edges;
        int   busy_n;
        logic ready_seen;
        in_valid = 1'b1;
        ALUop    = op;
        Ain      = a;
        Bin      = b;
        sb_q.push_back(model(op, a, b));
        acc_ok = 1'b0;
        waits  = 0;
        while (!acc_ok && waits < 50) begin
            @(negedge clk);
            if (in_ready) acc_ok = 1'b1;
            @(posedge clk);
            #1;
            waits++;
        end
        in_valid = 1'b0;
        ALUop    = $urandom_range(0, 7);
        Ain      = W'($urandom);
        Bin      = W'($urandom);
        check("accept", acc_ok, 1);
        // Single-cycle ops show out_valid right after the accepting edge; MUL
        // spends WIDTH further edges iterating with busy high.
        edges      = 0;
        busy_n     = 0;
        ready_seen = 1'b0;
        while (!out_valid && edges < 40) begin
            busy_n += int'(busy);
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", edges, (op == MUL) ? W : 0);
        if (op == MUL) begin
            check("mul_busy_cycles", busy_n, W);
            check("mul_in_ready_low", ready_seen, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Ain       = '0;
        Bin       = '0;
        ALUop     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", obs(), '0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);

        // First bundle on the first rising edge after reset release
        send(ADD, 16'h7FFF, 16'h0001);
        check("add_ovf", obs(), {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0});
        send(SUB, 16'h8000, 16'h0001);
        check("sub_ovf", obs(), {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1});
        send(SUB, 16'h0005, 16'h0005);
        check("sub_zero", obs(), {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
        send(MUL, 16'h0100, 16'h0100);
        check("mul_big", obs(), {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
        send(MUL, 16'h0012, 16'h0034);
        check("mul_small", obs(), {16'h03A8, 1'b0, 1'b0, 1'b0, 1'b0});
        send(SHL, 16'h8001, 16'h0001);
        check("shl_one", obs(), {16'h0002, 1'b0, 1'b0, 1'b0, 1'b1});
        send(SHL, 16'h1234, 16'h0000);
        check("shl_zero", obs(), {16'h1234, 1'b0, 1'b0, 1'b0, 1'b0});
        send(NOT, 16'hAAAA, 16'h00FF);
        send(XOR, 16'hFFFF, 16'hFFFF);
        send(SHL, 16'h00F1, 16'h001F);

        // Mixed random traffic, back-to-back through the pass-through path
        for (int i = 0; i < 16; i++) begin
            send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end

        // Backpressure: let the previous result drain, then hold a new one
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(OR, 16'h1234, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {obs(), out_valid, in_ready}, {16'h1235, 4'b0000, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        send(AND, 16'hF0F0, 16'h0FF0);
        check("bp_pass_valid", out_valid, 1);
        check("bp_pass_out", obs(), {16'h00F0, 4'b0000});

        // Reset five cycles into a multiply
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        ALUop    = MUL;
        Ain      = 16'h0003;
        Bin      = 16'h0005;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mid_mul_busy", busy, 1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_outputs", {obs(), out_valid, busy}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        send(ADD, 16'h0001, 16'h0001);
        check("post_rst_add", obs(), {16'h0002, 4'b0000});

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
